cjg_stack_ctrl: RTL and testbench

Frame sequencer for the CPU's hardware call stack. Accepts CALL, RET, INT and RETI requests from the control unit and sequences the single-word push/pop interface of the shift-register stack: one word (PC) for CALL/RET, two words (PC then SR) for interrupt entry/exit. Tracks stack occupancy and, when configured, guards against overflow and underflow. Sits between the control unit and the stack instance in the CPU top level.

---
 rtl/cjg_stack_ctrl_pkg.sv | 29 ++
 rtl/cjg_stack_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_cjg_stack_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cjg_stack_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cjg_stack_ctrl_pkg
// Shared definitions for the call-stack frame sequencer:
//   - request opcode encoding (CALL / RET / INT / RETI)
//   - sequencer state encoding
//   - width helper for the occupancy counter
// -----------------------------------------------------------------------------
package cjg_stack_ctrl_pkg;

    localparam logic [1:0] OP_CALL = 2'd0;
    localparam logic [1:0] OP_RET  = 2'd1;
    localparam logic [1:0] OP_INT  = 2'd2;
    localparam logic [1:0] OP_RETI = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PUSH_PC = 3'd1,
        ST_PUSH_SR = 3'd2,
        ST_POP_SR  = 3'd3,
        ST_POP_PC  = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    // Bits needed to count 0..depth inclusive.
    function automatic int depth_w(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/cjg_stack_ctrl.sv
// -----------------------------------------------------------------------------
// cjg_stack_ctrl
// Frame sequencer for the hardware call stack. Turns CALL/RET/INT/RETI
// requests into single-word push/pop cycles on a shift-register stack:
// CALL/RET move one word (PC); INT/RETI move two (PC then SR on entry,
// SR then PC on exit). Tracks stack occupancy.
//
// Optional feature: define STACK_GUARD_EN to reject requests that would
// overflow or underflow the stack (err_ovf / err_unf qualify done). Without
// it every frame executes, depth saturates at DEPTH and 0, and both error
// outputs are tied low.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   op_valid/op_ready/op  request handshake and opcode
//   pc_in, sr_in          values saved by CALL/INT
//   done, err_ovf/err_unf completion pulse and rejection qualifiers
//   pc_out, sr_out        values restored by RET/RETI (held between pops)
//   depth                 current stack occupancy
//   stk_d/stk_push/stk_pop/stk_q  stack instance interface
//   scan_in0/scan_en/test_mode/scan_out0  DFT hooks (scan_out0 driven 0)
// -----------------------------------------------------------------------------
module cjg_stack_ctrl
    import cjg_stack_ctrl_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 16,
    parameter int SR_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      op_valid,
    output logic                      op_ready,
    input  logic [1:0]                op,
    input  logic [WIDTH-1:0]          pc_in,
    input  logic [SR_WIDTH-1:0]       sr_in,
    output logic                      done,
    output logic                      err_ovf,
    output logic                      err_unf,
    output logic [WIDTH-1:0]          pc_out,
    output logic [SR_WIDTH-1:0]       sr_out,
    output logic [depth_w(DEPTH)-1:0] depth,
    output logic [WIDTH-1:0]          stk_d,
    output logic                      stk_push,
    output logic                      stk_pop,
    input  logic [WIDTH-1:0]          stk_q,
    input  logic                      scan_in0,
    input  logic                      scan_en,
    input  logic                      test_mode,
    output logic                      scan_out0
);

    localparam int            DW        = depth_w(DEPTH);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
    localparam logic [DW-1:0] DEPTH_ONE = DW'(1);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [1:0]            r_op;
    logic [WIDTH-1:0]      r_pc;
    logic [SR_WIDTH-1:0]   r_sr;
    logic [WIDTH-1:0]      r_pc_out;
    logic [SR_WIDTH-1:0]   r_sr_out;
    logic [DW-1:0]         r_depth;
    logic                  w_accept;
    logic                  w_rej_ovf;
    logic                  w_rej_unf;
    logic                  w_unused;

    assign w_accept = op_valid && (r_state == ST_IDLE);

`ifdef STACK_GUARD_EN
    localparam logic [DW-1:0] DEPTH_LIM_CALL = DW'(DEPTH - 1);
    localparam logic [DW-1:0] DEPTH_LIM_INT  = DW'(DEPTH - 2);
    localparam logic [DW-1:0] DEPTH_TWO      = DW'(2);

    logic r_err_ovf;
    logic r_err_unf;

    // Occupancy check of the incoming request (only meaningful while idle).
    always_comb begin
        w_rej_ovf = 1'b0;
        w_rej_unf = 1'b0;
        case (op)
            OP_CALL: w_rej_ovf = (r_depth > DEPTH_LIM_CALL);
            OP_INT:  w_rej_ovf = (r_depth > DEPTH_LIM_INT);
            OP_RET:  w_rej_unf = (r_depth < DEPTH_ONE);
            OP_RETI: w_rej_unf = (r_depth < DEPTH_TWO);
            default: begin
                w_rej_ovf = 1'b0;
                w_rej_unf = 1'b0;
            end
        endcase
    end

    // Rejection flags captured at accept and reported during DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else if (w_accept) begin
            r_err_ovf <= w_rej_ovf;
            r_err_unf <= w_rej_unf;
        end
    end

    assign err_ovf = (r_state == ST_DONE) && r_err_ovf;
    assign err_unf = (r_state == ST_DONE) && r_err_unf;
`else
    assign w_rej_ovf = 1'b0;
    assign w_rej_unf = 1'b0;
    assign err_ovf   = 1'b0;
    assign err_unf   = 1'b0;
`endif

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; rejected requests skip straight to DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_accept) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_rej_ovf || w_rej_unf) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    case (op)
                        OP_CALL: w_state_nxt = ST_PUSH_PC;
                        OP_INT:  w_state_nxt = ST_PUSH_PC;
                        OP_RET:  w_state_nxt = ST_POP_PC;
                        OP_RETI: w_state_nxt = ST_POP_SR;
                        default: w_state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_PUSH_PC: w_state_nxt = (r_op == OP_INT) ? ST_PUSH_SR : ST_DONE;
            ST_PUSH_SR: w_state_nxt = ST_DONE;
            ST_POP_SR:  w_state_nxt = ST_POP_PC;
            ST_POP_PC:  w_state_nxt = ST_DONE;
            ST_DONE:    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Request capture, occupancy tracking and restored-value registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op     <= OP_CALL;
            r_pc     <= {WIDTH{1'b0}};
            r_sr     <= {SR_WIDTH{1'b0}};
            r_pc_out <= {WIDTH{1'b0}};
            r_sr_out <= {SR_WIDTH{1'b0}};
            r_depth  <= {DW{1'b0}};
        end else begin
            if (w_accept) begin
                r_op <= op;
                r_pc <= pc_in;
                r_sr <= sr_in;
            end
            // Saturation keeps depth in range if the guard is compiled out.
            case (r_state)
                ST_PUSH_PC, ST_PUSH_SR: begin
                    if (r_depth < DEPTH_MAX) begin
                        r_depth <= r_depth + DEPTH_ONE;
                    end
                end
                ST_POP_SR: begin
                    r_sr_out <= stk_q[SR_WIDTH-1:0];
                    if (r_depth != {DW{1'b0}}) begin
                        r_depth <= r_depth - DEPTH_ONE;
                    end
                end
                ST_POP_PC: begin
                    r_pc_out <= stk_q;
                    if (r_depth != {DW{1'b0}}) begin
                        r_depth <= r_depth - DEPTH_ONE;
                    end
                end
                default: begin
                    r_depth <= r_depth;
                end
            endcase
        end
    end

    // Stack write data: SR is zero-extended into the stack word.
    always_comb begin
        stk_d = {WIDTH{1'b0}};
        case (r_state)
            ST_PUSH_PC: stk_d = r_pc;
            ST_PUSH_SR: stk_d = WIDTH'(r_sr);
            default:    stk_d = {WIDTH{1'b0}};
        endcase
    end

    assign op_ready  = (r_state == ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign stk_push  = (r_state == ST_PUSH_PC) || (r_state == ST_PUSH_SR);
    assign stk_pop   = (r_state == ST_POP_SR)  || (r_state == ST_POP_PC);
    assign pc_out    = r_pc_out;
    assign sr_out    = r_sr_out;
    assign depth     = r_depth;
    assign scan_out0 = 1'b0;
    assign w_unused  = &{1'b0, scan_in0, scan_en, test_mode};

endmodule

// File: tb/tb_cjg_stack_ctrl.sv
module tb_cjg_stack_ctrl;
    import cjg_stack_ctrl_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int SRW   = 8;
    localparam int DW    = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             op_valid = 1'b0;
    logic             op_ready;
    logic [1:0]       op = 2'd0;
    logic [WIDTH-1:0] pc_in = 32'h0;
    logic [SRW-1:0]   sr_in = 8'h0;
    logic             done, err_ovf, err_unf;
    logic [WIDTH-1:0] pc_out;
    logic [SRW-1:0]   sr_out;
    logic [DW-1:0]    depth;
    logic [WIDTH-1:0] stk_d;
    logic             stk_push, stk_pop;
    logic [WIDTH-1:0] stk_q;
    logic             scan_out0;

    int n_tests = 0;
    int n_fail  = 0;

    cjg_stack_ctrl dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op(op),
        .pc_in(pc_in), .sr_in(sr_in),
        .done(done), .err_ovf(err_ovf), .err_unf(err_unf),
        .pc_out(pc_out), .sr_out(sr_out), .depth(depth),
        .stk_d(stk_d), .stk_push(stk_push), .stk_pop(stk_pop), .stk_q(stk_q),
        .scan_in0(1'b0), .scan_en(1'b0), .test_mode(1'b0), .scan_out0(scan_out0)
    );

    always #5 clk = ~clk;

    // Behavioural shift-register stack sharing the controller reset.
    logic [WIDTH-1:0] bstk [DEPTH];
    assign stk_q = bstk[0];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) bstk[i] <= 32'h0;
        end else if (stk_push) begin
            for (int i = DEPTH - 1; i > 0; i--) bstk[i] <= bstk[i-1];
            bstk[0] <= stk_d;
        end else if (stk_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) bstk[i] <= bstk[i+1];
            bstk[DEPTH-1] <= 32'h0;
        end
    end

    // Reference model and scoreboard.
    typedef struct {
        logic [31:0] pc;
        logic [7:0]  sr;
        logic [4:0]  dep;
        logic        ovf;
        logic        unf;
        int          lat;
    } res_t;

    logic [31:0] m_stk[$];
    logic [31:0] exp_words[$];
    res_t        exp_res[$];
    logic [31:0] m_pc_out = 32'h0;
    logic [7:0]  m_sr_out = 8'h0;

    function automatic void m_push(input logic [31:0] w);
        if (m_stk.size() == DEPTH) void'(m_stk.pop_back());
        m_stk.push_front(w);
    endfunction

    function automatic logic [31:0] m_pop();
        logic [31:0] v;
        v = 32'h0;
        if (m_stk.size() > 0) v = m_stk.pop_front();
        return v;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        op_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        m_stk.delete();
        exp_words.delete();
        exp_res.delete();
        m_pc_out = 32'h0;
        m_sr_out = 8'h0;
    endtask

    // Issue one request, predict it, and score every cycle until done.
    task automatic run_op(input logic [1:0] o, input logic [31:0] pc, input logic [7:0] sr);
        res_t        r;
        logic [31:0] w;
        logic [31:0] t;
        logic        ovf, unf, got;
        int          pushes, pops, seen_push, seen_pop, k;
        ovf = 1'b0;
        unf = 1'b0;
`ifdef STACK_GUARD_EN
        case (o)
            OP_CALL: ovf = (m_stk.size() > DEPTH - 1);
            OP_INT:  ovf = (m_stk.size() > DEPTH - 2);
            OP_RET:  unf = (m_stk.size() < 1);
            default: unf = (m_stk.size() < 2);
        endcase
`endif
        pushes = 0;
        pops   = 0;
        if (ovf || unf) begin
            r.lat = 1;
        end else begin
            case (o)
                OP_CALL: begin
                    exp_words.push_back(pc); m_push(pc); pushes = 1; r.lat = 2;
                end
                OP_INT: begin
                    exp_words.push_back(pc); m_push(pc);
                    exp_words.push_back({24'h0, sr}); m_push({24'h0, sr});
                    pushes = 2; r.lat = 3;
                end
                OP_RET: begin
                    m_pc_out = m_pop(); pops = 1; r.lat = 2;
                end
                default: begin
                    t = m_pop(); m_sr_out = t[7:0]; m_pc_out = m_pop(); pops = 2; r.lat = 3;
                end
            endcase
        end
        r.pc  = m_pc_out;
        r.sr  = m_sr_out;
        r.dep = 5'(m_stk.size());
        r.ovf = ovf;
        r.unf = unf;
        exp_res.push_back(r);

        k = 0;
        while (!op_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (op_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_wait: op_ready=%b required 1", op_ready);
        end
        op = o; pc_in = pc; sr_in = sr; op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;

        got = 1'b0; seen_push = 0; seen_pop = 0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clk);
            n_tests++;
            if (stk_push && stk_pop) begin
                n_fail++;
                $display("FAIL push_pop_excl: both high in cycle %0d", c);
            end
            if (stk_push) begin
                seen_push++;
                n_tests++;
                if (exp_words.size() == 0) begin
                    n_fail++;
                    $display("FAIL push_extra: stk_d=%h with nothing expected", stk_d);
                end else begin
                    w = exp_words.pop_front();
                    if (stk_d !== w || c != seen_push) begin
                        n_fail++;
                        $display("FAIL push_word: stk_d=%h cycle %0d required %h cycle %0d", stk_d, c, w, seen_push);
                    end
                end
            end
            if (stk_pop) begin
                seen_pop++;
                n_tests++;
                if (c != seen_pop) begin
                    n_fail++;
                    $display("FAIL pop_cycle: pop in cycle %0d required %0d", c, seen_pop);
                end
            end
            if (done) begin
                got = 1'b1;
                r = exp_res.pop_front();
                n_tests++;
                if (c != r.lat || pc_out !== r.pc || sr_out !== r.sr || depth !== r.dep ||
                    err_ovf !== r.ovf || err_unf !== r.unf) begin
                    n_fail++;
                    $display("FAIL done_result: lat=%0d pc=%h sr=%h dep=%0d ovf=%b unf=%b required lat=%0d pc=%h sr=%h dep=%0d ovf=%b unf=%b",
                             c, pc_out, sr_out, depth, err_ovf, err_unf, r.lat, r.pc, r.sr, r.dep, r.ovf, r.unf);
                end
            end
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL done_timeout: no done within 8 cycles, required 1 pulse");
            void'(exp_res.pop_front());
        end
        n_tests++;
        if (seen_push != pushes || seen_pop != pops) begin
            n_fail++;
            $display("FAIL stack_ops: pushes=%0d pops=%0d required %0d %0d", seen_push, seen_pop, pushes, pops);
        end
        exp_words.delete();
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || op_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL done_single: done=%b op_ready=%b required 0 1", done, op_ready);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_tests++;
        if (op_ready !== 1'b1 || done !== 1'b0 || err_ovf !== 1'b0 || err_unf !== 1'b0 ||
            stk_push !== 1'b0 || stk_pop !== 1'b0 || stk_d !== 32'h0 || depth !== 5'd0 ||
            pc_out !== 32'h0 || sr_out !== 8'h0 || scan_out0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b done=%b push=%b pop=%b d=%h dep=%0d pc=%h sr=%h required 1 0 0 0 0 0 0 0",
                     op_ready, done, stk_push, stk_pop, stk_d, depth, pc_out, sr_out);
        end
    endtask

    task automatic test_call();
        run_op(OP_CALL, 32'h0000_0100, 8'h00);
        run_op(OP_RET,  32'h0000_0000, 8'h00);
    endtask

    task automatic test_int_reti();
        run_op(OP_INT,  32'h0000_0200, 8'hA5);
        run_op(OP_RETI, 32'h0000_0000, 8'h00);
    endtask

    task automatic test_nested();
        run_op(OP_CALL, 32'h0000_0010, 8'h00);
        run_op(OP_CALL, 32'h0000_0020, 8'h00);
        run_op(OP_RET,  32'h0000_0000, 8'h00);
        run_op(OP_RET,  32'h0000_0000, 8'h00);
    endtask

`ifdef STACK_GUARD_EN
    task automatic test_guard();
        run_op(OP_RET,  32'h0, 8'h00);
        run_op(OP_RETI, 32'h0, 8'h00);
        for (int i = 0; i < DEPTH; i++) run_op(OP_CALL, 32'h1000 + 32'(i), 8'h00);
        run_op(OP_CALL, 32'h0000_DEAD, 8'h00);
        run_op(OP_RET,  32'h0, 8'h00);
        run_op(OP_INT,  32'h0000_BEEF, 8'h11);
    endtask
`else
    task automatic test_saturate();
        for (int i = 0; i < DEPTH + 1; i++) run_op(OP_CALL, 32'h1000 + 32'(i), 8'h00);
        run_op(OP_RET, 32'h0, 8'h00);
    endtask
`endif

    task automatic test_back_to_back();
        int ready_c, done_n;
        apply_reset();
        op = OP_INT; pc_in = 32'h0000_0600; sr_in = 8'h3C; op_valid = 1'b1;
        @(posedge clk);
        #1;
        op = OP_CALL; pc_in = 32'h0000_0700;
        ready_c = 0; done_n = 0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 5) op_valid = 1'b0;
            if (op_ready && ready_c == 0) ready_c = c;
            if (done) done_n++;
            n_tests++;
            if (stk_push && stk_pop) begin
                n_fail++;
                $display("FAIL b2b_excl: push and pop both high in cycle %0d", c);
            end
            if (c == 1 || c == 2 || c == 5) begin
                n_tests++;
                if (!stk_push || stk_d !== ((c == 1) ? 32'h600 : (c == 2) ? 32'h3C : 32'h700)) begin
                    n_fail++;
                    $display("FAIL b2b_push: cycle %0d push=%b d=%h", c, stk_push, stk_d);
                end
            end
        end
        n_tests++;
        if (ready_c != 4 || done_n != 2 || depth !== 5'd3) begin
            n_fail++;
            $display("FAIL b2b_seq: ready_cycle=%0d dones=%0d depth=%0d required 4 2 3", ready_c, done_n, depth);
        end
    endtask

    task automatic test_reset_mid();
        op = OP_INT; pc_in = 32'h0000_0400; sr_in = 8'h5A; op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (stk_push !== 1'b1 || stk_d !== 32'h5A) begin
            n_fail++;
            $display("FAIL mid_push_sr: push=%b d=%h required 1 0000005a", stk_push, stk_d);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (stk_push !== 1'b0 || stk_d !== 32'h0 || op_ready !== 1'b1 || depth !== 5'd0 ||
            done !== 1'b0 || pc_out !== 32'h0 || sr_out !== 8'h0) begin
            n_fail++;
            $display("FAIL mid_reset: push=%b d=%h rdy=%b dep=%0d done=%b pc=%h sr=%h required 0 0 1 0 0 0 0",
                     stk_push, stk_d, op_ready, depth, done, pc_out, sr_out);
        end
        @(negedge clk);
        reset = 1'b1;
        m_stk.delete(); exp_words.delete(); exp_res.delete();
        m_pc_out = 32'h0; m_sr_out = 8'h0;
        run_op(OP_CALL, 32'h0000_0500, 8'h00);
        run_op(OP_RET,  32'h0000_0000, 8'h00);
    endtask

    initial begin
        test_reset();
        test_call();
        test_int_reti();
        test_nested();
`ifdef STACK_GUARD_EN
        test_guard();
`else
        test_saturate();
`endif
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
